// File: rtl/alarm_out_pkg.sv
// Shared types and default timing for the alarm output drivers.
// Holds the pulse stretcher state encoding and default ON/OFF times.
package alarm_out_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } pstr_state_t;

  localparam int PSTR_ON_DEF  = 1_000_000;
  localparam int PSTR_OFF_DEF = 500_000;
  localparam int PSTR_CW_DEF  = 20;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event-in / drive-out bundle of the pulse stretcher.
// trigger: request strobe; pulse, busy, pending: stretcher status.
interface pulse_stretcher_if;

  logic trigger;
  logic pulse;
  logic busy;
  logic pending;

  modport master (
    output trigger,
    input  pulse,
    input  busy,
    input  pending
  );

  modport slave (
    input  trigger,
    output pulse,
    output busy,
    output pending
  );

endinterface

// File: rtl/cycle_timer.sv
// Reloadable up-counter that flags the last cycle of an interval.
// Ports: clock, reset (async high), clear, limit (terminal count), done.
module cycle_timer #(
  parameter int CW = 20
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic [CW-1:0] limit,
  output logic          done
);

  logic [CW-1:0] count_q;

  // Saturates at limit so it can never wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_q != limit) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign done = (count_q == limit);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches event strobes into min-width pulses with a min holdoff.
// Ports: clock, reset (async high), io.slave (trigger/pulse/busy/pending).
// Build option: define RETRIGGER_EN so triggers in ON extend the pulse.
module pulse_stretcher
  import alarm_out_pkg::*;
#(
  parameter int ON_CYCLES  = PSTR_ON_DEF,
  parameter int OFF_CYCLES = PSTR_OFF_DEF,
  parameter int CW         = PSTR_CW_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  pulse_stretcher_if.slave     io
);

  localparam logic [CW-1:0] ON_LIM  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LIM = CW'(OFF_CYCLES - 1);

  pstr_state_t   state_q, state_d;
  logic          pend_q, pend_d;
  logic          clr;
  logic          done;
  logic [CW-1:0] limit;

  cycle_timer #(
    .CW(CW)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (clr),
    .limit (limit),
    .done  (done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    limit = '0;
    unique case (1'b1)
      (state_q == ON):  limit = ON_LIM;
      (state_q == OFF): limit = OFF_LIM;
      default: ;
    endcase
  end

  // clr is raised on every state entry; IDLE keeps the timer parked at 0.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (io.trigger) state_d = ON;
      end
      ON: begin
        if (done) begin
          state_d = OFF;
          clr     = 1'b1;
        end
`ifdef RETRIGGER_EN
        if (io.trigger) begin
          state_d = ON;
          clr     = 1'b1;
        end
`else
        if (io.trigger) pend_d = 1'b1;
`endif
      end
      OFF: begin
        if (done) begin
          clr = 1'b1;
          if (pend_q || io.trigger) begin
            state_d = ON;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (io.trigger) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        clr     = 1'b1;
      end
    endcase
  end

  assign io.pulse   = (state_q == ON);
  assign io.busy    = (state_q != IDLE);
  assign io.pending = pend_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher (ON=4, OFF=3).
// Deadline-based reference model; directed cases then random traffic.
module tb_pulse_stretcher;

  localparam int ON  = 4;
  localparam int OFF = 3;

  logic clk;
  logic rst;

  pulse_stretcher_if ps_if ();

  pulse_stretcher #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .CW         (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .io    (ps_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: absolute edge indices at which the pulse and holdoff end.
  longint ne;
  longint on_end;
  longint off_end;
  bit     q;

  task automatic model_reset();
    on_end  = ne - 1;
    off_end = ne - 1;
    q       = 1'b0;
  endtask

  task automatic start_at(input longint e);
    on_end  = e + ON;
    off_end = e + ON + OFF;
  endtask

  task automatic model_step(input bit trg);
    longint e;
    bit in_on;
    bit in_off;
    e      = ne;
    in_on  = (e - 1) < on_end;
    in_off = !in_on && ((e - 1) < off_end);
    if (!in_on && !in_off) begin
      if (trg) start_at(e);
    end else if (in_on) begin
`ifdef RETRIGGER_EN
      if (trg) start_at(e);
`else
      if (trg) q = 1'b1;
`endif
    end else if (e == off_end) begin
      if (q || trg) begin
        start_at(e);
        q = 1'b0;
      end
    end else if (trg) begin
      q = 1'b1;
    end
    ne++;
  endtask

  int hi_cnt;
  int busy_cnt;

  // Called just after a negedge; returns just after the next negedge.
  task automatic run_cycle(input bit trg, input string tag);
    ps_if.trigger = trg;
    @(posedge clk);
    model_step(trg);
    @(negedge clk);
    check_eq({tag, ".pulse"}, int'(ps_if.pulse),
             int'((ne - 1) < on_end));
    check_eq({tag, ".busy"}, int'(ps_if.busy),
             int'((ne - 1) < off_end));
    check_eq({tag, ".pending"}, int'(ps_if.pending), int'(q));
    hi_cnt   += int'(ps_if.pulse);
    busy_cnt += int'(ps_if.busy);
  endtask

  task automatic run_pat(input bit pat[$], input int gap, input string tag);
    foreach (pat[i]) run_cycle(pat[i], tag);
    for (int i = 0; i < gap; i++) run_cycle(1'b0, tag);
  endtask

  // Reset pulse strictly between clock edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check_eq({tag, ".rst_pulse"}, int'(ps_if.pulse), 0);
    check_eq({tag, ".rst_busy"}, int'(ps_if.busy), 0);
    check_eq({tag, ".rst_pend"}, int'(ps_if.pending), 0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    bit pat[$];
    int p;
    ps_if.trigger = 1'b0;
    rst = 1'b1;
    ne  = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset.pulse", int'(ps_if.pulse), 0);
    check_eq("reset.busy", int'(ps_if.busy), 0);
    check_eq("reset.pending", int'(ps_if.pending), 0);
    rst = 1'b0;
    run_cycle(1'b0, "idle");

    hi_cnt   = 0;
    busy_cnt = 0;
    pat = '{1'b1};
    run_pat(pat, 12, "single");
    check_eq("single.width", hi_cnt, ON);
    check_eq("single.busy_len", busy_cnt, ON + OFF);

    hi_cnt = 0;
    pat = '{1'b1, 1'b0, 1'b1};
    run_pat(pat, 15, "in_on");
`ifdef RETRIGGER_EN
    check_eq("in_on.width", hi_cnt, ON + 2);
`else
    check_eq("in_on.width", hi_cnt, 2 * ON);
`endif

    pat = {};
    for (int i = 0; i < 20; i++) pat.push_back(1'b1);
    run_pat(pat, 12, "held");

    pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_pat(pat, 12, "last_off");

    pat = '{1'b1, 1'b0, 1'b0};
    run_pat(pat, 0, "mid_on");
    async_reset("mid_on");
    hi_cnt = 0;
    pat = '{1'b1};
    run_pat(pat, 12, "after_rst");
    check_eq("after_rst.width", hi_cnt, ON);

    hi_cnt = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    run_pat(pat, 15, "in_off");
    check_eq("in_off.width", hi_cnt, 2 * ON);

    p = 30;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) p = $urandom_range(5, 95);
      run_cycle($urandom_range(0, 99) < p, "rand");
      if ($urandom_range(0, 59) == 0) async_reset("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
